// File: rtl/sm_trace_buf_pkg.sv
// Shared types for the schoolRISCV instruction trace buffer.
package sm_trace_buf_pkg;

  localparam int TR_REC_W = 96;

  typedef enum logic [1:0] {
    TRS_IDLE  = 2'd0,
    TRS_ARMED = 2'd1,
    TRS_POST  = 2'd2,
    TRS_DONE  = 2'd3
  } trs_t;

  // One retired-instruction record as stored in the buffer.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] a0;
  } tr_rec_t;

endpackage

// File: rtl/sm_trace_buf_ram.sv
// DEPTH x 96 record store: one synchronous write port, one asynchronous
// read port. The array is not reset; occupancy is tracked by the control.
module sm_trace_buf_ram
  import sm_trace_buf_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  tr_rec_t       wdata,
  input  logic [AW-1:0] raddr,
  output tr_rec_t       rdata
);

  tr_rec_t mem [DEPTH];

  // Capture write.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sm_trace_buf.sv
// Circular instruction trace buffer: arm, capture until a trigger plus
// POST_TRIG more records, then drain oldest-first over valid/ready.
module sm_trace_buf
  import sm_trace_buf_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int POST_TRIG = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     tr_valid,
  input  logic [31:0]              tr_pc,
  input  logic [31:0]              tr_instr,
  input  logic [31:0]              tr_a0,
  input  logic                     arm,
  input  logic                     trig,
  input  logic                     trig_pc_en,
  input  logic [31:0]              trig_pc,
  output logic [1:0]               state,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [31:0]              rd_pc,
  output logic [31:0]              rd_instr,
  output logic [31:0]              rd_a0,
  output logic                     rd_last
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  trs_t          state_q, state_n;
  logic [AW-1:0] wptr_q, wptr_n, rptr_q, rptr_n;
  logic [CW-1:0] count_q, count_n, rem_q, rem_n, post_q, post_n;
  logic          wr_en, trig_hit, pop;
  tr_rec_t       wr_rec, rd_rec;

  assign trig_hit = tr_valid & (trig | (trig_pc_en & (tr_pc == trig_pc)));
  // rem is only nonzero in DONE: cleared by arm/reset, loaded on DONE entry.
  assign rd_valid = (state_q == TRS_DONE) && (rem_q != '0);
  assign rd_last  = rd_valid && (rem_q == CW'(1));
  assign pop      = rd_valid & rd_ready;
  assign wr_rec   = '{pc: tr_pc, instr: tr_instr, a0: tr_a0};

  // Next-state, pointer and counter logic; arm overrides every other event.
  always_comb begin
    state_n = state_q;
    wptr_n  = wptr_q;
    count_n = count_q;
    post_n  = post_q;
    rptr_n  = rptr_q;
    rem_n   = rem_q;
    wr_en   = 1'b0;
    if (arm) begin
      state_n = TRS_ARMED;
      wptr_n  = '0;
      count_n = '0;
      post_n  = '0;
      rem_n   = '0;
    end else begin
      case (state_q)
        TRS_ARMED, TRS_POST: begin
          if (tr_valid) begin
            wr_en   = 1'b1;
            wptr_n  = wptr_q + AW'(1);
            count_n = (count_q == CW'(DEPTH)) ? count_q : count_q + CW'(1);
            if (state_q == TRS_ARMED) begin
              if (trig_hit) begin
                if (POST_TRIG == 0) state_n = TRS_DONE;
                else begin
                  state_n = TRS_POST;
                  post_n  = CW'(POST_TRIG);
                end
              end
            end else begin
              post_n = post_q - CW'(1);
              if (post_q == CW'(1)) state_n = TRS_DONE;
            end
          end
          // Oldest record sits count entries behind the write pointer; when
          // full, count mod DEPTH is 0 and the oldest is at wptr itself.
          if (state_n == TRS_DONE) begin
            rptr_n = wptr_n - count_n[AW-1:0];
            rem_n  = count_n;
          end
        end
        TRS_DONE: begin
          if (pop) begin
            rptr_n = rptr_q + AW'(1);
            rem_n  = rem_q - CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Control registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= TRS_IDLE;
      wptr_q  <= '0;
      count_q <= '0;
      post_q  <= '0;
      rptr_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_n;
      wptr_q  <= wptr_n;
      count_q <= count_n;
      post_q  <= post_n;
      rptr_q  <= rptr_n;
      rem_q   <= rem_n;
    end
  end

  sm_trace_buf_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wptr_q),
    .wdata (wr_rec),
    .raddr (rptr_q),
    .rdata (rd_rec)
  );

  assign state    = state_q;
  assign count    = count_q;
  assign rd_pc    = rd_rec.pc;
  assign rd_instr = rd_rec.instr;
  assign rd_a0    = rd_rec.a0;

endmodule

// File: tb/tb_sm_trace_buf.sv
// Directed bench: dut_a (DEPTH=16, POST_TRIG=4) and dut_b (POST_TRIG=0)
// share the trace stream; each has its own arm/trig/readout controls.
module tb_sm_trace_buf;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tr_valid = 1'b0;
  logic [31:0] tr_pc = '0, tr_instr = '0, tr_a0 = '0;
  logic        a_arm = 1'b0, a_trig = 1'b0, a_pc_en = 1'b0, a_ready = 1'b0;
  logic        b_arm = 1'b0, b_trig = 1'b0, b_pc_en = 1'b0, b_ready = 1'b0;
  logic [31:0] trig_pc = '0;

  logic [1:0]  a_state, b_state;
  logic [4:0]  a_count, b_count;
  logic        a_rd_valid, b_rd_valid, a_rd_last, b_rd_last;
  logic [31:0] a_rd_pc, a_rd_instr, a_rd_a0, b_rd_pc, b_rd_instr, b_rd_a0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sm_trace_buf #(.DEPTH(16), .POST_TRIG(4)) dut_a (
    .clk(clk), .rst(rst), .tr_valid(tr_valid), .tr_pc(tr_pc),
    .tr_instr(tr_instr), .tr_a0(tr_a0), .arm(a_arm), .trig(a_trig),
    .trig_pc_en(a_pc_en), .trig_pc(trig_pc), .state(a_state),
    .count(a_count), .rd_valid(a_rd_valid), .rd_ready(a_ready),
    .rd_pc(a_rd_pc), .rd_instr(a_rd_instr), .rd_a0(a_rd_a0),
    .rd_last(a_rd_last)
  );

  sm_trace_buf #(.DEPTH(16), .POST_TRIG(0)) dut_b (
    .clk(clk), .rst(rst), .tr_valid(tr_valid), .tr_pc(tr_pc),
    .tr_instr(tr_instr), .tr_a0(tr_a0), .arm(b_arm), .trig(b_trig),
    .trig_pc_en(b_pc_en), .trig_pc(trig_pc), .state(b_state),
    .count(b_count), .rd_valid(b_rd_valid), .rd_ready(b_ready),
    .rd_pc(b_rd_pc), .rd_instr(b_rd_instr), .rd_a0(b_rd_a0),
    .rd_last(b_rd_last)
  );

  function automatic logic [31:0] f_instr(input logic [31:0] pc);
    return 32'h0001_0013 + pc;
  endfunction

  function automatic logic [31:0] f_a0(input logic [31:0] pc);
    return ~pc;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic rec(input logic [31:0] pc);
    tr_valid = 1'b1;
    tr_pc    = pc;
    tr_instr = f_instr(pc);
    tr_a0    = f_a0(pc);
  endtask

  initial begin
    int idx;
    int c;
    logic [3:0] ptn;
    ptn = 4'b1001;  // rd_ready 1,0,0,1 repeating (bit c%4, LSB first)

    // Reset with tr_valid active.
    rec(32'h0);
    cyc(); cyc();
    chk("rst_state", 32'(a_state), 32'd0);
    chk("rst_count", 32'(a_count), 32'd0);
    chk("rst_rd_valid", 32'(a_rd_valid), 32'd0);
    rst = 1'b0;
    tr_valid = 1'b0;
    cyc();

    // arm together with a PC match: ARMED, nothing captured.
    trig_pc = 32'h40;
    a_pc_en = 1'b1;
    a_arm = 1'b1;
    rec(32'h40);
    cyc();
    a_arm = 1'b0;
    chk("arm_match_state", 32'(a_state), 32'd1);
    chk("arm_match_count", 32'(a_count), 32'd0);
    chk("idle_b_count", 32'(b_count), 32'd0);

    // Stream pc 0x00.. with a gap in ARMED; trigger on 0x40 (17th record).
    for (int k = 0; k <= 16; k++) begin
      rec(32'(k * 4));
      cyc();
      if (k == 2) begin
        tr_valid = 1'b0;
        cyc();
        chk("armed_gap_count", 32'(a_count), 32'd3);
      end
    end
    chk("trig_state_post", 32'(a_state), 32'd2);
    chk("wrap_count_sat", 32'(a_count), 32'd16);

    // POST: gap must not consume a post slot.
    rec(32'h44); cyc();
    tr_valid = 1'b0; cyc();
    chk("post_gap_state", 32'(a_state), 32'd2);
    rec(32'h48); cyc();
    rec(32'h4C); cyc();
    chk("post_before_last", 32'(a_state), 32'd2);
    rec(32'h50); cyc();
    tr_valid = 1'b0;
    chk("done_state", 32'(a_state), 32'd3);
    chk("done_count", 32'(a_count), 32'd16);
    chk("done_rd_valid", 32'(a_rd_valid), 32'd1);

    // Readout 0x14..0x50 under backpressure.
    idx = 0;
    c = 0;
    while (idx < 16 && c < 200) begin
      a_ready = ptn[c % 4];
      chk("rd_valid", 32'(a_rd_valid), 32'd1);
      chk("rd_pc", a_rd_pc, 32'h14 + 32'(idx * 4));
      chk("rd_instr", a_rd_instr, f_instr(32'h14 + 32'(idx * 4)));
      chk("rd_a0", a_rd_a0, f_a0(32'h14 + 32'(idx * 4)));
      chk("rd_last", 32'(a_rd_last), (idx == 15) ? 32'd1 : 32'd0);
      cyc();
      if (a_ready) idx++;
      c++;
    end
    a_ready = 1'b0;
    chk("readout_complete", 32'(idx), 32'd16);
    chk("drained_rd_valid", 32'(a_rd_valid), 32'd0);
    chk("drained_state", 32'(a_state), 32'd3);
    chk("drained_count", 32'(a_count), 32'd16);

    // Second capture (trigger on 12th record), then arm mid-readout.
    trig_pc = 32'h12C;
    a_arm = 1'b1;
    cyc();
    a_arm = 1'b0;
    for (int k = 0; k < 16; k++) begin
      rec(32'h100 + 32'(k * 4));
      cyc();
    end
    tr_valid = 1'b0;
    chk("cap2_state", 32'(a_state), 32'd3);
    chk("cap2_count", 32'(a_count), 32'd16);
    a_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("cap2_rd_pc", a_rd_pc, 32'h100 + 32'(k * 4));
      cyc();
    end
    chk("cap2_rec5_pc", a_rd_pc, 32'h110);
    a_arm = 1'b1;
    cyc();
    a_arm = 1'b0;
    a_ready = 1'b0;
    chk("abort_rd_valid", 32'(a_rd_valid), 32'd0);
    chk("abort_state", 32'(a_state), 32'd1);
    chk("abort_count", 32'(a_count), 32'd0);

    // dut_b: POST_TRIG=0, manual trig on the 3rd record.
    b_arm = 1'b1;
    cyc();
    b_arm = 1'b0;
    for (int k = 0; k < 3; k++) begin
      rec(32'h200 + 32'(k * 4));
      b_trig = (k == 2);
      cyc();
    end
    tr_valid = 1'b0;
    b_trig = 1'b0;
    chk("b_done_state", 32'(b_state), 32'd3);
    chk("b_done_count", 32'(b_count), 32'd3);
    b_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk("b_rd_valid", 32'(b_rd_valid), 32'd1);
      chk("b_rd_pc", b_rd_pc, 32'h200 + 32'(k * 4));
      chk("b_rd_last", 32'(b_rd_last), (k == 2) ? 32'd1 : 32'd0);
      cyc();
    end
    b_ready = 1'b0;
    chk("b_drained", 32'(b_rd_valid), 32'd0);
    chk("b_count_kept", 32'(b_count), 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sm_trace_buf.md
# sm_trace_buf

On-chip instruction trace buffer for the schoolRISCV single-cycle core. It sits directly downstream of `sm_cpu` in `sm_top`. Each executed instruction's record is captured into a circular buffer: `pc`, `instr`, and register file x10 (`a0`). Capture is armed and stopped by a PC-match or manual trigger. The oldest-first history is then drained through a valid/ready readout port, giving the same per-cycle view as the simulation trace but on hardware.

## Interface
Parameters:
- `DEPTH`, 16: number of records; power of two, ≥ 4.
- `POST_TRIG`, 4: records captured after the trigger record; must satisfy 0 ≤ POST_TRIG < DEPTH.

Ports:
- `clk` input, 1 bit: CPU clock (`cpuClk`). This is the only clock.
- `rst` input, 1 bit: reset, synchronous and active-high.
- `tr_valid` input, 1 bit: a record is presented this cycle (one retired instruction).
- `tr_pc` input, 32 bits: pc of the retiring instruction.
- `tr_instr` input, 32 bits: instruction word.
- `tr_a0` input, 32 bits: value of x10.
- `arm` input, 1 bit: pulse; clears the buffer and starts capture.
- `trig` input, 1 bit: manual trigger, qualified by `tr_valid`.
- `trig_pc_en` input, 1 bit: enables the PC-match trigger.
- `trig_pc` input, 32 bits: PC-match trigger value.
- `state` output, 2 bits: 0 IDLE, 1 ARMED, 2 POST, 3 DONE.
- `count` output, $clog2(DEPTH)+1 bits: number of valid records held.
- `rd_valid` output, 1 bit: a readout record is available.
- `rd_ready` input, 1 bit: consumer accepts the record.
- `rd_pc` output, 32 bits: pc field of the head record.
- `rd_instr` output, 32 bits: instr field of the head record.
- `rd_a0` output, 32 bits: a0 field of the head record.
- `rd_last` output, 1 bit: the head record is the final one.

## Operation
- Reset: `state`=IDLE, `wptr`=0, `count`=0, `rptr`=0, post counter=0, `rd_valid`=0, `rd_last`=0. The `rd_*` data outputs are don't-care while `rd_valid`=0.
- `arm` in any state:
  - next state ARMED; `wptr`, `count`, and the post counter are cleared.
  - a `tr_valid` in the same cycle is not captured.
  - `arm` has priority over every other event, including triggers and readout pops.
- ARMED, each cycle with `tr_valid`=1:
  - write `{pc,instr,a0}` at `wptr`; `wptr` advances modulo DEPTH.
  - `count` increments and saturates at DEPTH; on overflow the oldest record is overwritten.
- Trigger condition: `tr_valid & (trig | (trig_pc_en & tr_pc==trig_pc))`. It is evaluated only in ARMED.
- On the trigger, the trigger record is written as normal. Then:
  - if POST_TRIG=0, next state is DONE.
  - otherwise next state is POST and the post counter is loaded with POST_TRIG.
- POST, each `tr_valid`: write as in ARMED and decrement the post counter. The write that brings the counter to 0 moves the state to DONE. Triggers are ignored in POST.
- DONE:
  - no further capture.
  - `rptr` is loaded with `(wptr - count) mod DEPTH` on entry; the remaining count starts at `count`.
  - `rd_valid` = (remaining > 0).
  - a pop occurs when `rd_valid & rd_ready`; it advances `rptr` and decrements the remaining count.
  - `rd_last` = (remaining == 1).
  - after the last pop, `rd_valid` goes to 0 and the state stays DONE until `arm`.
  - `count` output keeps the captured total and is not decremented by pops.
- IDLE: `tr_valid`, `trig`, and `rd_ready` are ignored.

## Timing
- All state, pointers, counters, and `count` update on the rising edge of `clk`.
- The trigger compare is combinational on the current inputs. The write and the state change take effect at the same edge.
- Readout data is combinational from the buffer at `rptr` (asynchronous read). `rd_pc`, `rd_instr`, and `rd_a0` are valid in the same cycle as `rd_valid`.
- Readout throughput is one record per cycle while `rd_ready`=1.
- `rd_valid` rises the cycle after entry to DONE. It never drops without a pop or `arm`.
- `rst` or `arm` mid-readout aborts the readout. `rd_valid`=0 on the following cycle.

## Structure
- State codes (`TRS_IDLE`, `TRS_ARMED`, `TRS_POST`, `TRS_DONE`) and the record width (96) go in a shared header `sm_trace.vh`, next to `sr_cpu.vh`.
- Sub-module `sm_trace_ram`:
  - DEPTH×96 memory, one synchronous write port, one asynchronous read port.
  - no reset on the array.
- Top-level hookup in `sm_top`:
  - `tr_valid` = `clkEnable`.
  - `tr_pc`, `tr_instr`, `tr_a0` = `sm_cpu.pc`, `sm_cpu.instr`, `rf[10]`.

## Test plan
- Reset check: assert `rst` for 2 cycles, with `tr_valid`=1 throughout. Required: `state`=0, `count`=0, `rd_valid`=0.
- PC-match with wrap:
  - set DEPTH=16, POST_TRIG=4, `trig_pc`=0x40; arm.
  - stream pc 0x00,0x04,… one record per cycle.
  - required: trigger at 0x40 (17th record), DONE after pc 0x50, `count`=16.
  - readout gives pc 0x14…0x50 in order, with `rd_last` only on 0x50.
- Backpressure: in DONE, toggle `rd_ready` 1,0,0,1,… Required: no duplicated or skipped records, and data stays stable while `rd_ready`=0.
- POST_TRIG=0 with manual `trig` on the 3rd record: required DONE on the next cycle, `count`=3, readout of 3 records.
- Simultaneous events:
  - `arm` and a PC match in the same cycle: required ARMED, `count`=0, no capture.
  - `arm` during the readout of record 5 of 16: `rd_valid`=0 on the next cycle and state ARMED.
- `tr_valid`=0 gaps in ARMED and POST: required no writes and no change to the post counter.
